// File: rtl/mem_seq_pkg.sv
// -----------------------------------------------------------------------------
// mem_seq_pkg
// Shared types and constants for the latch-memory sequencer.
//   - ADDR_W / DATA_W / WORDS : geometry of the 4-word x 3-bit latch array
//   - state_e                 : sequencer FSM states
//   - max3()                  : helper used to size the shared phase timer
// -----------------------------------------------------------------------------
package mem_seq_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 3;
    localparam int WORDS  = 4;

    // IDLE  : waiting for a command (cmd_ready high)
    // SETUP : SEL/D presented with E low, before the pulse or before sampling Q
    // PULSE : E high, SEL/D frozen
    // HOLD  : E low again, SEL/D still frozen
    // RESP  : read data held on the response channel until accepted
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        RESP  = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// -----------------------------------------------------------------------------
// mem_sequencer_if
// Bundles the command channel, the response channel and the latch-memory pins
// of the sequencer.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer keeps valid and its
// payload stable until that edge; ready may be asserted independently of
// valid. Nothing is transferred while reset is asserted.
//
//   cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_data : command channel (in to seq)
//   rsp_valid/rsp_ready/rsp_addr/rsp_data        : read response (out of seq)
//   mem_d/mem_sel/mem_e                          : drive the latch array
//   mem_q                                        : latch array read data
//
// Modports:
//   master : the sequencer (initiator toward the latch memory)
//   slave  : the environment (command source, response sink, memory)
// -----------------------------------------------------------------------------
interface mem_sequencer_if;
    import mem_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;

    logic [DATA_W-1:0] mem_d;
    logic [ADDR_W-1:0] mem_sel;
    logic              mem_e;
    logic [DATA_W-1:0] mem_q;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_addr, rsp_data,
        input  rsp_ready,
        output mem_d, mem_sel, mem_e,
        input  mem_q
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_addr, rsp_data,
        output rsp_ready,
        input  mem_d, mem_sel, mem_e,
        output mem_q
    );

endinterface

// File: rtl/mem_seq_timer.sv
// -----------------------------------------------------------------------------
// mem_seq_timer
// Loadable down-counter shared by the SETUP, PULSE and HOLD phases.
//   clk, rst_n  : clock, asynchronous active-low reset (count clears to 0)
//   load_i      : load load_val_i on the next edge (has priority over dec_i)
//   load_val_i  : value to load (phase length minus one)
//   dec_i       : decrement on the next edge; saturates at zero
//   zero_o      : count is zero (last cycle of the current phase)
//   count_o     : current count, for observation
// -----------------------------------------------------------------------------
module mem_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o  = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mem_sequencer.sv
// -----------------------------------------------------------------------------
// mem_sequencer
// Clocked initiator for a 4-word x 3-bit level-sensitive latch memory.
// Turns write/read commands into SEL/D setup, an E pulse and a hold phase,
// and returns read data on a response channel. Commands are serialized:
// one command in flight, no pipelining; writes produce no response.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mem_sequencer_if.master (command, response, memory pins)
//   state_o    : current FSM state, for observation
//
// Parameters (all must be >= 1):
//   SETUP_CYC : cycles SEL/D are stable with E low before the pulse / sample
//   PULSE_CYC : cycles E stays high during a write
//   HOLD_CYC  : cycles SEL/D stay put after E falls
//
// Every memory pin and every response field comes straight from a flop, so
// the latch enable never sees a combinational glitch, and the asynchronous
// reset pulls E low immediately even in the middle of a pulse.
// -----------------------------------------------------------------------------
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_sequencer_if.master      bus,
    output state_e               state_o
);

    localparam int TMR_W = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

    // The timer holds "cycles left minus one", so a phase ends when it hits 0.
    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 1);

    state_e            state_q,     state_d;
    logic              wr_q,        wr_d;
    logic              mem_e_q,     mem_e_d;
    logic [ADDR_W-1:0] mem_sel_q,   mem_sel_d;
    logic [DATA_W-1:0] mem_d_q,     mem_d_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q,  rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_dec;
    logic              tmr_zero;
    logic [TMR_W-1:0]  tmr_count;

    mem_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero),
        .count_o    (tmr_count)
    );

    // -------------------------------------------------------------------------
    // Next-state and output-register logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        mem_e_d      = mem_e_q;
        mem_sel_d    = mem_sel_q;
        mem_d_d      = mem_d_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_addr_d   = rsp_addr_q;
        rsp_data_d   = rsp_data_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                // cmd_ready is exactly (state_q == IDLE), so valid alone
                // completes the handshake here.
                if (bus.cmd_valid) begin
                    state_d      = SETUP;
                    wr_d         = bus.cmd_wr;
                    mem_sel_d    = bus.cmd_addr;
                    // Reads leave D alone: there is no reason to toggle it.
                    if (bus.cmd_wr) begin
                        mem_d_d = bus.cmd_data;
                    end
                    tmr_load     = 1'b1;
                    tmr_load_val = SETUP_LD;
                end
            end

            SETUP: begin
                if (tmr_zero) begin
                    if (wr_q) begin
                        state_d      = PULSE;
                        mem_e_d      = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = PULSE_LD;
                    end else begin
                        // Q has had SETUP_CYC cycles to settle on SEL.
                        state_d     = RESP;
                        rsp_data_d  = bus.mem_q;
                        rsp_addr_d  = mem_sel_q;
                        rsp_valid_d = 1'b1;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            PULSE: begin
                if (tmr_zero) begin
                    state_d      = HOLD;
                    mem_e_d      = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            HOLD: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                mem_e_d     = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            mem_e_q     <= 1'b0;
            mem_sel_q   <= '0;
            mem_d_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            mem_e_q     <= mem_e_d;
            mem_sel_q   <= mem_sel_d;
            mem_d_q     <= mem_d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.mem_e     = mem_e_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_d     = mem_d_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rsp_data_q;
    assign state_o       = state_q;

    // The count itself is only needed through the zero flag.
    logic unused_tmr;
    assign unused_tmr = ^tmr_count;

endmodule

// File: tb/tb_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_sequencer
// Directed bench for mem_sequencer with default timing (SETUP=1, PULSE=2,
// HOLD=1). A behavioural latch array answers the memory pins; expected read
// responses are queued when a read is issued and checked by a monitor.
// -----------------------------------------------------------------------------
module tb_mem_sequencer;
    import mem_seq_pkg::*;

    // ------------------------------------------------------------ clock/reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_sequencer_if bus();
    state_e state;

    mem_sequencer #(
        .SETUP_CYC (1),
        .PULSE_CYC (2),
        .HOLD_CYC  (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state)
    );

    // ------------------------------------------------------------ latch array
    logic [DATA_W-1:0] mem [WORDS] = '{default: '0};
    always @(negedge clk) begin
        if (bus.mem_e) mem[bus.mem_sel] <= bus.mem_d;
    end
    assign bus.mem_q = mem[bus.mem_sel];

    // ------------------------------------------------------------ bookkeeping
    int total = 0;
    int pass  = 0;
    int hs_cnt = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers a command and returns after the accepting edge; cyc counts the
    // edges waited, including the accepting one. cmd_valid is left high.
    task automatic send(input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int cyc);
        logic ok;
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        cyc = 0;
        do begin
            ok = bus.cmd_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!ok && cyc < 50);
        if (!ok) chk("cmd_accept_timeout", 0, 1);
    endtask

    // ------------------------------------------------------------ monitors
    always @(negedge clk) begin
        if (rst_n && bus.cmd_valid && bus.cmd_ready) hs_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_word", int'({bus.rsp_addr, bus.rsp_data}), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    logic [DATA_W-1:0] wr_tab [4] = '{3'd1, 3'd2, 3'd4, 3'd7};
    logic [DATA_W-1:0] rd_tab [4] = '{3'd1, 3'd2, 3'd4, 3'd7};

    initial begin
        int c;
        int hs_base;

        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;

        // ---- reset values
        step(2);
        chk("rst_mem_e",     int'(bus.mem_e),     0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_mem_sel",   int'(bus.mem_sel),   0);
        chk("rst_mem_d",     int'(bus.mem_d),     0);
        chk("rst_rsp_addr",  int'(bus.rsp_addr),  0);
        chk("rst_rsp_data",  int'(bus.rsp_data),  0);
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_state",     int'(state),         int'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // ---- write addr=2 data=5, cycle-accurate
        send(1'b1, 2'd2, 3'd5, c);
        bus.cmd_valid = 1'b0;
        chk("wr_c1_sel",   int'(bus.mem_sel),   2);
        chk("wr_c1_d",     int'(bus.mem_d),     5);
        chk("wr_c1_e",     int'(bus.mem_e),     0);
        chk("wr_c1_ready", int'(bus.cmd_ready), 0);
        step(1);
        chk("wr_c2_e",     int'(bus.mem_e),     1);
        chk("wr_c2_sel",   int'(bus.mem_sel),   2);
        chk("wr_c2_d",     int'(bus.mem_d),     5);
        step(1);
        chk("wr_c3_e",     int'(bus.mem_e),     1);
        chk("wr_c3_sel",   int'(bus.mem_sel),   2);
        chk("wr_c3_d",     int'(bus.mem_d),     5);
        step(1);
        chk("wr_c4_e",     int'(bus.mem_e),     0);
        chk("wr_c4_sel",   int'(bus.mem_sel),   2);
        chk("wr_c4_d",     int'(bus.mem_d),     5);
        chk("wr_c4_ready", int'(bus.cmd_ready), 0);
        step(1);
        chk("wr_c5_ready", int'(bus.cmd_ready), 1);
        chk("wr_mem2",     int'(mem[2]),        5);

        // ---- read addr=2, immediate accept
        exp_q.push_back({2'd2, 3'd5});
        send(1'b0, 2'd2, 3'd0, c);
        bus.cmd_valid = 1'b0;
        chk("rd_c1_valid", int'(bus.rsp_valid), 0);
        chk("rd_c1_e",     int'(bus.mem_e),     0);
        chk("rd_c1_d",     int'(bus.mem_d),     5);
        step(1);
        chk("rd_c2_valid", int'(bus.rsp_valid), 1);
        chk("rd_c2_e",     int'(bus.mem_e),     0);
        chk("rd_c2_data",  int'(bus.rsp_data),  5);
        chk("rd_c2_addr",  int'(bus.rsp_addr),  2);
        step(1);
        chk("rd_c3_valid", int'(bus.rsp_valid), 0);
        chk("rd_c3_ready", int'(bus.cmd_ready), 1);

        // ---- response backpressure for 3 cycles
        bus.rsp_ready = 1'b0;
        exp_q.push_back({2'd2, 3'd5});
        send(1'b0, 2'd2, 3'd0, c);
        bus.cmd_valid = 1'b0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", int'(bus.rsp_valid), 1);
            chk("bp_data",  int'(bus.rsp_data),  5);
            chk("bp_addr",  int'(bus.rsp_addr),  2);
            chk("bp_ready", int'(bus.cmd_ready), 0);
            step(1);
        end
        bus.rsp_ready = 1'b1;
        step(1);
        chk("bp_release_valid", int'(bus.rsp_valid), 0);
        chk("bp_release_ready", int'(bus.cmd_ready), 1);

        // ---- reset in the second PULSE cycle (word 1 excluded afterwards)
        send(1'b1, 2'd1, 3'd6, c);
        bus.cmd_valid = 1'b0;
        step(2);
        chk("rp_pre_e",     int'(bus.mem_e), 1);
        chk("rp_pre_state", int'(state),     int'(PULSE));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rp_e",       int'(bus.mem_e),     0);
        chk("rp_state",   int'(state),         int'(IDLE));
        chk("rp_sel",     int'(bus.mem_sel),   0);
        chk("rp_d",       int'(bus.mem_d),     0);
        chk("rp_rsp_vld", int'(bus.rsp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        chk("rp_after_ready", int'(bus.cmd_ready), 1);

        // ---- reset with a pending response: response is discarded
        bus.rsp_ready = 1'b0;
        send(1'b0, 2'd2, 3'd0, c);
        bus.cmd_valid = 1'b0;
        step(1);
        chk("rr_pre_valid", int'(bus.rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_valid", int'(bus.rsp_valid), 0);
        chk("rr_ready", int'(bus.cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        step(1);
        chk("rr_after_valid", int'(bus.rsp_valid), 0);

        // ---- cmd_valid held high: 4 writes then 4 reads back-to-back
        hs_base = hs_cnt;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 2'(i), wr_tab[i], c);
            if (i > 0) chk("held_wr_interval", c, 5);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({2'(i), rd_tab[i]});
            send(1'b0, 2'(i), 3'd0, c);
            chk("held_rd_interval", c, (i == 0) ? 5 : 3);
        end
        bus.cmd_valid = 1'b0;
        step(4);
        chk("held_handshakes", hs_cnt - hs_base, 8);
        chk("held_mem0", int'(mem[0]), 1);
        chk("held_mem1", int'(mem[1]), 2);
        chk("held_mem2", int'(mem[2]), 4);
        chk("held_mem3", int'(mem[3]), 7);
        chk("held_idle", int'(state), int'(IDLE));

        // ---- every expected response must have been seen
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
